piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
- Parallel-in/serial-out transmitter, WIDTH bits per frame, MSB first.
- Feeds the 8-bit serial-in shift register. The first bit sent lands in its w[7], so after WIDTH shifting edges the receiver holds the original word unchanged.
- Adds load handshake, frame-valid output, bit counter and back-to-back frame support.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..32.
- IDLE_LEVEL, 0, value driven on sout when no bit is being sent.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  parallel word offered on load_data.
- load_data  input  WIDTH  word to serialize; sampled only on an accepting edge.
- load_ready  output  1  transmitter can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  high while sout carries a frame bit; the receiver shifts on edges where it is high.
- busy  output  1  frame in progress; equals the state not being IDLE.
- done  output  1  one-cycle pulse after the final bit of a frame has been sent.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, shreg=0, cnt=0.
  - sout=IDLE_LEVEL, sout_valid=0, busy=0, done=0, load_ready=1.
  - Reset asserted mid-frame aborts the frame immediately. No done pulse; the partial frame is discarded.
- States: IDLE, SHIFT, plus PARITY when PARITY_EN is defined.
- Accept: an edge with load_valid and load_ready both high.
- IDLE:
  - load_ready=1, sout=IDLE_LEVEL, sout_valid=0.
  - On accept: shreg<=load_data, cnt<=0, state<=SHIFT.
- SHIFT:
  - sout=shreg[WIDTH-1] (combinational from the register), sout_valid=1.
  - Each edge: shreg<=shreg<<1, cnt<=cnt+1.
- Last bit (cnt==WIDTH-1):
  - load_ready=1 (combinational), so a new frame can start with zero gap.
  - On that edge, if accept: reload shreg, cnt<=0, stay in SHIFT, done<=1.
  - Otherwise: state<=IDLE, done<=1.
- Outside the last-bit cycle, load_ready=0 in SHIFT; load_valid is ignored and load_data is never sampled.
- Latency:
  - First data bit appears on sout in the cycle after the accept edge.
  - A frame occupies exactly WIDTH sout_valid cycles.
  - done is high for the one cycle following the final bit.
- Counter: width clog2(WIDTH), never exceeds WIDTH-1; no wrap-around beyond the terminal value.
- done is registered and lasts one cycle. With back-to-back frames it coincides with the first bit of the next frame.
- load_valid held high continuously gives continuous streaming with sout_valid stuck at 1.

Optional Feature:
- Macro: PISO_SHIFT_TX_PARITY_EN.
- Defined:
  - After the last data bit, state goes to PARITY for one cycle.
  - In PARITY: sout = even parity (XOR) of the accepted word, held in a 1-bit register captured at accept; sout_valid=1.
  - load_ready is high in PARITY instead of at the last data bit. The back-to-back and done rules apply at the exit from PARITY.
  - A frame is WIDTH+1 bits.
- Undefined: the PARITY state, parity register and logic are absent; behaviour is exactly as above.

Test Plan:
- Reset: rst_n=0 with load_valid=1 -> sout=0, sout_valid=0, load_ready=1, done=0. No accept occurs while in reset.
- Single frame: load_data=8'hB4 accepted from IDLE -> sout sequence 1,0,1,1,0,1,0,0 over 8 sout_valid cycles, then done=1 for 1 cycle, then IDLE. An 8-bit serial-in register clocked on the sout_valid edges holds 8'hB4.
- Back-to-back: 8'hA5 then 8'h3C, the second offered on the last-bit cycle -> 16 consecutive sout_valid cycles carrying 10100101 00111100. done pulses alongside the first bit of frame 2 and again after frame 2.
- Ignored load: load_valid=1 with 8'hFF at bit 3 of the 8'h00 frame -> load_ready=0, sout stays all zeros, frame unaffected.
- Mid-frame reset: rst_n pulsed low at bit 4 of 8'hF0 -> outputs return to reset values immediately, no done pulse, next accepted word 8'h81 sends 10000001.
- Parity (macro defined): 8'hB4 -> 9 bits 1,0,1,1,0,1,0,0 then parity 0. 8'hB5 -> final bit 1. done follows the parity bit.

Source files
------------

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle for piso_shift_tx.
// master = word producer / serial consumer, slave = the transmitter.
interface piso_shift_tx_if #(
   parameter int unsigned WIDTH = 8
);
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             done;

   modport master (
      output load_valid, load_data,
      input  load_ready, sout, sout_valid, busy, done
   );

   modport slave (
      input  load_valid, load_data,
      output load_ready, sout, sout_valid, busy, done
   );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter, MSB first, with zero-gap back-to-back frames.
// Optional even-parity trailer bit enabled by defining PISO_SHIFT_TX_PARITY_EN.
module piso_shift_tx #(
   parameter int unsigned WIDTH      = 8,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic          clock,
   input  logic          rst_n,
   piso_shift_tx_if.slave bus
);
   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_SHIFT_TX_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
   logic par_q;
`else
   typedef enum logic {IDLE, SHIFT} state_e;
`endif

   state_e           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [CW-1:0]    cnt_q;
   logic             done_q;
   logic             last_bit;
   logic             ready;
   logic             accept;
   logic             sout_c;
   logic             valid_c;

   always_comb begin
      last_bit = (state_q == SHIFT) && (cnt_q == LAST);
`ifdef PISO_SHIFT_TX_PARITY_EN
      ready    = (state_q == IDLE) || (state_q == PARITY);
`else
      ready    = (state_q == IDLE) || last_bit;
`endif
      accept   = bus.load_valid && ready;
   end

   always_comb begin
      sout_c  = IDLE_LEVEL;
      valid_c = 1'b0;
      case (state_q)
         SHIFT: begin
            sout_c  = shreg_q[WIDTH-1];
            valid_c = 1'b1;
         end
`ifdef PISO_SHIFT_TX_PARITY_EN
         PARITY: begin
            sout_c  = par_q;
            valid_c = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // A reload on the frame's exit edge overrides the shift and keeps state in SHIFT.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  shreg_q <= bus.load_data;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
`ifdef PISO_SHIFT_TX_PARITY_EN
                  par_q   <= ^bus.load_data;
`endif
               end
            end
            SHIFT: begin
               shreg_q <= shreg_q << 1;
               if (!last_bit) begin
                  cnt_q <= cnt_q + CW'(1);
               end else begin
                  cnt_q <= '0;
`ifdef PISO_SHIFT_TX_PARITY_EN
                  state_q <= PARITY;
`else
                  done_q <= 1'b1;
                  if (accept) begin
                     shreg_q <= bus.load_data;
                  end else begin
                     state_q <= IDLE;
                  end
`endif
               end
            end
`ifdef PISO_SHIFT_TX_PARITY_EN
            PARITY: begin
               done_q <= 1'b1;
               cnt_q  <= '0;
               if (accept) begin
                  shreg_q <= bus.load_data;
                  par_q   <= ^bus.load_data;
                  state_q <= SHIFT;
               end else begin
                  state_q <= IDLE;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.load_ready = ready;
   assign bus.sout       = sout_c;
   assign bus.sout_valid = valid_c;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = done_q;
endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed self-checking bench for piso_shift_tx (WIDTH=8, IDLE_LEVEL=0).
// With PISO_SHIFT_TX_PARITY_EN defined only the reset and parity scenarios run.
module tb_piso_shift_tx;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx = '0;
   int         checks = 0;
   int         errors = 0;

   piso_shift_tx_if #(.WIDTH(8)) bus ();

   piso_shift_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
      .clock (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference 8-bit serial-in receiver: first bit sent ends in rx[7].
   always @(posedge clk) begin
      if (rst_n && bus.sout_valid) rx <= {rx[6:0], bus.sout};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hAA;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.sout !== 1'b0) begin errors++; $display("FAIL rst_sout got %b exp 0", bus.sout); end
         checks++; if (bus.sout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.sout_valid); end
         checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.load_ready); end
         checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.done); end
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
      end
      bus.load_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy got %b exp 0", bus.busy); end
   endtask

   task automatic test_single_frame();
      logic [7:0] exp;
      exp = 8'b10110100;
      bus.load_data  = 8'hB4;
      bus.load_valid = 1'b1;
      checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL sf_idle_ready got %b exp 1", bus.load_ready); end
      tick();
      bus.load_valid = 1'b0;
      bus.load_data  = 8'h00;
      for (int unsigned i = 0; i < 8; i++) begin
         checks++; if (bus.sout !== exp[7-i]) begin errors++; $display("FAIL sf_bit%0d got %b exp %b", i, bus.sout, exp[7-i]); end
         checks++; if (bus.sout_valid !== 1'b1) begin errors++; $display("FAIL sf_valid%0d got %b exp 1", i, bus.sout_valid); end
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL sf_busy%0d got %b exp 1", i, bus.busy); end
         checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL sf_done%0d got %b exp 0", i, bus.done); end
         checks++; if (bus.load_ready !== (i == 7)) begin errors++; $display("FAIL sf_ready%0d got %b exp %b", i, bus.load_ready, (i == 7)); end
         tick();
      end
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL sf_done_pulse got %b exp 1", bus.done); end
      checks++; if (bus.sout_valid !== 1'b0) begin errors++; $display("FAIL sf_end_valid got %b exp 0", bus.sout_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sf_end_busy got %b exp 0", bus.busy); end
      checks++; if (rx !== 8'hB4) begin errors++; $display("FAIL sf_rx got %h exp b4", rx); end
      tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL sf_done_clear got %b exp 0", bus.done); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e1;
      logic [7:0] e2;
      e1 = 8'b10100101;
      e2 = 8'b00111100;
      bus.load_data  = 8'hA5;
      bus.load_valid = 1'b1;
      tick();
      bus.load_valid = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         checks++; if (bus.sout !== e1[7-i]) begin errors++; $display("FAIL b2b_f1_bit%0d got %b exp %b", i, bus.sout, e1[7-i]); end
         checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_f1_done%0d got %b exp 0", i, bus.done); end
         if (i == 7) begin
            bus.load_data  = 8'h3C;
            bus.load_valid = 1'b1;
            checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL b2b_last_ready got %b exp 1", bus.load_ready); end
         end
         tick();
      end
      bus.load_valid = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         checks++; if (bus.sout !== e2[7-i]) begin errors++; $display("FAIL b2b_f2_bit%0d got %b exp %b", i, bus.sout, e2[7-i]); end
         checks++; if (bus.sout_valid !== 1'b1) begin errors++; $display("FAIL b2b_f2_valid%0d got %b exp 1", i, bus.sout_valid); end
         checks++; if (bus.done !== (i == 0)) begin errors++; $display("FAIL b2b_f2_done%0d got %b exp %b", i, bus.done, (i == 0)); end
         if (i == 0) begin
            checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL b2b_rx1 got %h exp a5", rx); end
         end
         tick();
      end
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b exp 1", bus.done); end
      checks++; if (bus.sout_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b exp 0", bus.sout_valid); end
      checks++; if (rx !== 8'h3C) begin errors++; $display("FAIL b2b_rx2 got %h exp 3c", rx); end
      tick();
   endtask

   task automatic test_ignored_load();
      bus.load_data  = 8'h00;
      bus.load_valid = 1'b1;
      tick();
      bus.load_valid = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i == 3) begin
            bus.load_data  = 8'hFF;
            bus.load_valid = 1'b1;
            checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL ign_ready got %b exp 0", bus.load_ready); end
         end else begin
            bus.load_valid = 1'b0;
         end
         checks++; if (bus.sout !== 1'b0) begin errors++; $display("FAIL ign_bit%0d got %b exp 0", i, bus.sout); end
         checks++; if (bus.sout_valid !== 1'b1) begin errors++; $display("FAIL ign_valid%0d got %b exp 1", i, bus.sout_valid); end
         tick();
      end
      bus.load_data = 8'h00;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ign_done got %b exp 1", bus.done); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %b exp 0", bus.busy); end
      checks++; if (rx !== 8'h00) begin errors++; $display("FAIL ign_rx got %h exp 00", rx); end
      tick();
   endtask

   task automatic test_midframe_reset();
      logic [7:0] e1;
      logic [7:0] e2;
      e1 = 8'b11110000;
      e2 = 8'b10000001;
      bus.load_data  = 8'hF0;
      bus.load_valid = 1'b1;
      tick();
      bus.load_valid = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         checks++; if (bus.sout !== e1[7-i]) begin errors++; $display("FAIL mr_bit%0d got %b exp %b", i, bus.sout, e1[7-i]); end
         tick();
      end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mr_busy_pre got %b exp 1", bus.busy); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.sout_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b exp 0", bus.sout_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mr_busy got %b exp 0", bus.busy); end
      checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL mr_ready got %b exp 1", bus.load_ready); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mr_done got %b exp 0", bus.done); end
      checks++; if (bus.sout !== 1'b0) begin errors++; $display("FAIL mr_sout got %b exp 0", bus.sout); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mr_no_done got %b exp 0", bus.done); end
      bus.load_data  = 8'h81;
      bus.load_valid = 1'b1;
      tick();
      bus.load_valid = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         checks++; if (bus.sout !== e2[7-i]) begin errors++; $display("FAIL mr_f2_bit%0d got %b exp %b", i, bus.sout, e2[7-i]); end
         checks++; if (bus.sout_valid !== 1'b1) begin errors++; $display("FAIL mr_f2_valid%0d got %b exp 1", i, bus.sout_valid); end
         tick();
      end
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL mr_f2_done got %b exp 1", bus.done); end
      checks++; if (rx !== 8'h81) begin errors++; $display("FAIL mr_rx got %h exp 81", rx); end
      tick();
   endtask

`ifdef PISO_SHIFT_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] words [2];
      logic [8:0] frames [2];
      logic [8:0] f;
      words[0]  = 8'hB4;
      words[1]  = 8'hB5;
      frames[0] = 9'b1_0110_1000;
      frames[1] = 9'b1_0110_1011;
      for (int unsigned w = 0; w < 2; w++) begin
         f = frames[w];
         bus.load_data  = words[w];
         bus.load_valid = 1'b1;
         tick();
         bus.load_valid = 1'b0;
         for (int unsigned i = 0; i < 9; i++) begin
            checks++; if (bus.sout !== f[8-i]) begin errors++; $display("FAIL par%0d_bit%0d got %b exp %b", w, i, bus.sout, f[8-i]); end
            checks++; if (bus.sout_valid !== 1'b1) begin errors++; $display("FAIL par%0d_valid%0d got %b exp 1", w, i, bus.sout_valid); end
            checks++; if (bus.load_ready !== (i == 8)) begin errors++; $display("FAIL par%0d_ready%0d got %b exp %b", w, i, bus.load_ready, (i == 8)); end
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL par%0d_done%0d got %b exp 0", w, i, bus.done); end
            tick();
         end
         checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL par%0d_done_pulse got %b exp 1", w, bus.done); end
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL par%0d_end_busy got %b exp 0", w, bus.busy); end
         tick();
      end
   endtask
`endif

   initial begin
      bus.load_valid = 1'b0;
      bus.load_data  = 8'h00;
      test_reset();
`ifdef PISO_SHIFT_TX_PARITY_EN
      test_parity();
`else
      test_single_frame();
      test_back_to_back();
      test_ignored_load();
      test_midframe_reset();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
